// File: rtl/ysyx_22040750_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040750_mdu_pkg
// Brief    : Shared widths, op-select bit indices, FSM state type and
//            special-case constants for the EX-stage multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_22040750_mdu_pkg;

  localparam int XLEN = 64;
  localparam int WLEN = 32;

  // Bit positions inside the one-hot {REM,DIV,MULH,MUL} select
  localparam int OP_MUL  = 0;
  localparam int OP_MULH = 1;
  localparam int OP_DIV  = 2;
  localparam int OP_REM  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  localparam logic [XLEN-1:0] ALL_ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] SIGNED_MIN   = {1'b1, {(XLEN-1){1'b0}}};
  // 32-bit signed minimum, already sign-extended to the full datapath
  localparam logic [XLEN-1:0] SIGNED_MIN_W = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] sext_word(input logic [WLEN-1:0] v);
    return {{(XLEN-WLEN){v[WLEN-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext_word(input logic [WLEN-1:0] v);
    return {{(XLEN-WLEN){1'b0}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040750_div_core.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040750_div_core
// Brief    : One restoring-division step. Shifts the next dividend bit (MSB
//            of the quotient register) into the partial remainder, subtracts
//            the divisor when it fits, and shifts the quotient bit in.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040750_div_core
#(
  parameter int XLEN = ysyx_22040750_mdu_pkg::XLEN
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quot_next
);

  logic [XLEN:0]   w_shifted;
  logic [XLEN+1:0] w_diff;
  logic            w_fits;

  // Trial subtraction is one bit wider than the shifted remainder so the
  // borrow cleanly tells whether the divisor fits.
  always_comb begin
    w_shifted = {rem, quot[XLEN-1]};
    w_diff    = {1'b0, w_shifted} - {2'b00, divisor};
    w_fits    = ~w_diff[XLEN+1];
    rem_next  = w_fits ? w_diff[XLEN-1:0] : w_shifted[XLEN-1:0];
    quot_next = {quot[XLEN-2:0], w_fits};
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_22040750_ex_mdu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040750_ex_mdu
// Brief    : Iterative multiply/divide unit of the EX stage. Handles MUL,
//            MULH(U), DIV(U), REM(U) and W variants, one bit per cycle, with
//            a valid/ready handshake towards EX/MEM.
//            Build option YSYX_22040750_MDU_FAST_MUL_EN: multiplication uses
//            a single-cycle combinational product (latency 2) instead of
//            the shift-add loop.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040750_ex_mdu
#(
  parameter int XLEN = ysyx_22040750_mdu_pkg::XLEN
) (
  input  logic            I_sys_clk,
  input  logic            I_rst,
  input  logic            I_start,
  input  logic [3:0]      I_op_sel,
  input  logic            I_signed,
  input  logic            I_word,
  input  logic [XLEN-1:0] I_src1,
  input  logic [XLEN-1:0] I_src2,
  input  logic            I_flush,
  input  logic            I_out_ready,
  output logic            O_busy,
  output logic            O_out_valid,
  output logic [XLEN-1:0] O_result
);

  import ysyx_22040750_mdu_pkg::*;

  localparam int              CNT_W   = $clog2(XLEN) + 1;
  localparam int              PW      = 2 * XLEN;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mdu_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_op;
  logic             r_word;
  logic             r_prod_neg;   // also the quotient sign
  logic             r_rem_neg;
  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_prod;
  logic [XLEN-1:0]  r_mplier;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quot;
  logic [XLEN-1:0]  r_divisor;

  logic             w_op_onehot;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_word_eff;
  logic [XLEN-1:0]  w_ext1;
  logic [XLEN-1:0]  w_ext2;
  logic             w_neg1;
  logic             w_neg2;
  logic [XLEN-1:0]  w_mag1;
  logic [XLEN-1:0]  w_mag2;
  logic             w_div0;
  logic             w_ovf;
  logic             w_special;
  logic [XLEN-1:0]  w_special_res;
  logic [CNT_W-1:0] w_cnt_init;

  logic [PW-1:0]    w_prod_step;
  logic [PW-1:0]    w_prod_fin;
  logic [PW-1:0]    w_prod_fix;
  logic [XLEN-1:0]  w_rem_nx;
  logic [XLEN-1:0]  w_quot_nx;
  logic [XLEN-1:0]  w_quot_fix;
  logic [XLEN-1:0]  w_rem_fix;
  logic [XLEN-1:0]  w_sel;
  logic [XLEN-1:0]  w_calc_res;

  assign O_busy = (r_state != ST_IDLE);

  // Issue-side decode: operand extension, magnitudes and the divide special cases
  always_comb begin
    w_op_onehot = $onehot(I_op_sel);
    w_is_mul    = I_op_sel[OP_MUL] | I_op_sel[OP_MULH];
    w_is_div    = I_op_sel[OP_DIV] | I_op_sel[OP_REM];
    // MULH has no W form, so the word flag is dropped for it
    w_word_eff  = I_word & ~I_op_sel[OP_MULH];

    if (w_word_eff) begin
      w_ext1 = I_signed ? sext_word(I_src1[WLEN-1:0]) : zext_word(I_src1[WLEN-1:0]);
      w_ext2 = I_signed ? sext_word(I_src2[WLEN-1:0]) : zext_word(I_src2[WLEN-1:0]);
    end else begin
      w_ext1 = I_src1;
      w_ext2 = I_src2;
    end

    w_neg1 = I_signed & w_ext1[XLEN-1];
    w_neg2 = I_signed & w_ext2[XLEN-1];
    w_mag1 = w_neg1 ? -w_ext1 : w_ext1;
    w_mag2 = w_neg2 ? -w_ext2 : w_ext2;

    w_div0    = w_is_div & (w_ext2 == '0);
    w_ovf     = w_is_div & I_signed & (w_ext2 == ALL_ONES) &
                (w_ext1 == (w_word_eff ? SIGNED_MIN_W : SIGNED_MIN));
    w_special = w_div0 | w_ovf;

    if (w_div0) begin
      w_special_res = I_op_sel[OP_DIV] ? ALL_ONES :
                      (w_word_eff ? sext_word(I_src1[WLEN-1:0]) : I_src1);
    end else begin
      // Overflow: the quotient equals the (extended) dividend, i.e. MIN
      w_special_res = I_op_sel[OP_DIV] ? w_ext1 : '0;
    end

    w_cnt_init = w_word_eff ? CNT_W'(WLEN) : CNT_W'(XLEN);
`ifdef YSYX_22040750_MDU_FAST_MUL_EN
    if (w_is_mul) begin
      w_cnt_init = CNT_ONE;
    end
`endif
  end

  ysyx_22040750_div_core #(
    .XLEN (XLEN)
  ) u_div_core (
    .rem       (r_rem),
    .quot      (r_quot),
    .divisor   (r_divisor),
    .rem_next  (w_rem_nx),
    .quot_next (w_quot_nx)
  );

  // Iteration datapath: next product, sign fix-up and final result select
  always_comb begin
    w_prod_step = r_prod + (r_mplier[0] ? r_mcand : '0);
`ifdef YSYX_22040750_MDU_FAST_MUL_EN
    w_prod_fin  = {{XLEN{1'b0}}, r_mcand[XLEN-1:0]} * {{XLEN{1'b0}}, r_mplier};
`else
    w_prod_fin  = w_prod_step;
`endif
    w_prod_fix = r_prod_neg ? -w_prod_fin : w_prod_fin;
    w_quot_fix = r_prod_neg ? -w_quot_nx  : w_quot_nx;
    w_rem_fix  = r_rem_neg  ? -w_rem_nx   : w_rem_nx;

    if (r_op[OP_MUL]) begin
      w_sel = w_prod_fix[XLEN-1:0];
    end else if (r_op[OP_MULH]) begin
      w_sel = w_prod_fix[PW-1:XLEN];
    end else if (r_op[OP_DIV]) begin
      w_sel = w_quot_fix;
    end else begin
      w_sel = w_rem_fix;
    end

    w_calc_res = r_word ? sext_word(w_sel[WLEN-1:0]) : w_sel;
  end

  // Control FSM with registered result/valid and the working registers
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_word      <= 1'b0;
      r_prod_neg  <= 1'b0;
      r_rem_neg   <= 1'b0;
      r_mcand     <= '0;
      r_prod      <= '0;
      r_mplier    <= '0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_divisor   <= '0;
      O_result    <= '0;
      O_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (I_start && !I_flush && w_op_onehot) begin
            r_op       <= I_op_sel;
            r_word     <= w_word_eff;
            r_prod_neg <= w_neg1 ^ w_neg2;
            r_rem_neg  <= w_neg1;
            r_mcand    <= {{XLEN{1'b0}}, w_mag1};
            r_mplier   <= w_mag2;
            r_prod     <= '0;
            r_rem      <= '0;
            // W dividends start at the top so their MSB shifts out first
            r_quot     <= w_word_eff ? (w_mag1 << WLEN) : w_mag1;
            r_divisor  <= w_mag2;
            r_cnt      <= w_cnt_init;
            if (w_special) begin
              O_result    <= w_special_res;
              O_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state     <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (I_flush) begin
            O_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_prod   <= w_prod_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_rem    <= w_rem_nx;
            r_quot   <= w_quot_nx;
            r_cnt    <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
              O_result    <= w_calc_res;
              O_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (I_flush || I_out_ready) begin
            O_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          O_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040750_ex_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22040750_ex_mdu
// Brief    : Directed table-driven bench for the EX-stage multiply/divide
//            unit, plus hand sequences for backpressure, flush and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040750_ex_mdu;

  localparam logic [3:0] M_MUL  = 4'b0001;
  localparam logic [3:0] M_MULH = 4'b0010;
  localparam logic [3:0] M_DIV  = 4'b0100;
  localparam logic [3:0] M_REM  = 4'b1000;
  localparam int         NV     = 20;
  localparam int         TMO    = 200;

  logic        I_sys_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic        I_start = 1'b0;
  logic [3:0]  I_op_sel = 4'b0000;
  logic        I_signed = 1'b0;
  logic        I_word = 1'b0;
  logic [63:0] I_src1 = 64'd0;
  logic [63:0] I_src2 = 64'd0;
  logic        I_flush = 1'b0;
  logic        I_out_ready = 1'b1;
  logic        O_busy;
  logic        O_out_valid;
  logic [63:0] O_result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic        sgn;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [NV];

  ysyx_22040750_ex_mdu dut (
    .I_sys_clk   (I_sys_clk),
    .I_rst       (I_rst),
    .I_start     (I_start),
    .I_op_sel    (I_op_sel),
    .I_signed    (I_signed),
    .I_word      (I_word),
    .I_src1      (I_src1),
    .I_src2      (I_src2),
    .I_flush     (I_flush),
    .I_out_ready (I_out_ready),
    .O_busy      (O_busy),
    .O_out_valid (O_out_valid),
    .O_result    (O_result)
  );

  always #5 I_sys_clk = ~I_sys_clk;

  function automatic int mul_lat(input int n);
`ifdef YSYX_22040750_MDU_FAST_MUL_EN
    return 2;
`else
    return n;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic sgn, input logic word,
                       input logic [63:0] a, input logic [63:0] b);
    I_start  = 1'b1;
    I_op_sel = op;
    I_signed = sgn;
    I_word   = word;
    I_src1   = a;
    I_src2   = b;
  endtask

  // Waits (bounded) for O_out_valid; returns the number of edges taken
  task automatic wait_valid(output int n);
    n = 0;
    while (!O_out_valid && n < TMO) begin
      @(negedge I_sys_clk);
      I_start = 1'b0;
      n++;
    end
  endtask

  task automatic run_op(input string nm, input logic [3:0] op, input logic sgn,
                        input logic word, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat);
    int n;
    @(negedge I_sys_clk);
    I_out_ready = 1'b1;
    drive(op, sgn, word, a, b);
    @(negedge I_sys_clk);
    I_start = 1'b0;
    n = 1;
    if (!O_out_valid) begin
      int m;
      wait_valid(m);
      n += m;
    end
    chk({nm, "_lat"}, 64'(n), 64'(lat));
    chk({nm, "_res"}, O_result, exp);
    @(negedge I_sys_clk);
    chk({nm, "_drop"}, {62'd0, O_out_valid, O_busy}, 64'd0);
  endtask

  initial begin
    int n;
    logic seen;

    vecs[0]  = '{"mul_s",      M_MUL,  1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, mul_lat(65)};
    vecs[1]  = '{"mulh_s",     M_MULH, 1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, mul_lat(65)};
    vecs[2]  = '{"divu",       M_DIV,  1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 65};
    vecs[3]  = '{"remu",       M_REM,  1'b0, 1'b0, 64'd100, 64'd7, 64'd2, 65};
    vecs[4]  = '{"div_s",      M_DIV,  1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65};
    vecs[5]  = '{"rem_s",      M_REM,  1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[6]  = '{"div0",       M_DIV,  1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[7]  = '{"rem0",       M_REM,  1'b0, 1'b0, 64'd5, 64'd0, 64'd5, 1};
    vecs[8]  = '{"div_ovf",    M_DIV,  1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[9]  = '{"rem_ovf",    M_REM,  1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    vecs[10] = '{"mulw",       M_MUL,  1'b1, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, mul_lat(33)};
    vecs[11] = '{"divuw",      M_DIV,  1'b0, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'd4, 64'd4, 33};
    vecs[12] = '{"mulhu_max",  M_MULH, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, mul_lat(65)};
    vecs[13] = '{"mulh_wign",  M_MULH, 1'b0, 1'b1, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'd1, mul_lat(65)};
    vecs[14] = '{"remw_s",     M_REM,  1'b1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[15] = '{"divw_ovf",   M_DIV,  1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[16] = '{"divuw0",     M_DIV,  1'b0, 1'b1, 64'd4660, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[17] = '{"remuw0",     M_REM,  1'b0, 1'b1, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1};
    vecs[18] = '{"remu_big",   M_REM,  1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, 65};
    vecs[19] = '{"div_s_neg",  M_DIV,  1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65};

    // Reset state
    repeat (3) @(negedge I_sys_clk);
    chk("reset_state", {O_result[61:0], O_out_valid, O_busy}, 64'd0);
    I_rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].sgn, vecs[i].word,
             vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // Backpressure: result held while downstream is stalled, spurious start ignored
    @(negedge I_sys_clk);
    I_out_ready = 1'b0;
    drive(M_MUL, 1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    @(negedge I_sys_clk);
    I_start = 1'b0;
    wait_valid(n);
    chk("bp_first", O_result, 64'hFFFF_FFFF_FFFF_FFEB);
    for (int i = 0; i < 5; i++) begin
      @(negedge I_sys_clk);
      if (i == 2) drive(M_DIV, 1'b0, 1'b0, 64'd100, 64'd7);
      else        I_start = 1'b0;
      chk("bp_hold", {O_result[61:0], O_out_valid, O_busy},
          {62'h3FFF_FFFF_FFFF_FFEB, 1'b1, 1'b1});
    end
    I_start     = 1'b0;
    I_out_ready = 1'b1;
    @(negedge I_sys_clk);
    chk("bp_release", {62'd0, O_out_valid, O_busy}, 64'd0);

    // Non-one-hot select is ignored
    @(negedge I_sys_clk);
    drive(4'b0011, 1'b0, 1'b0, 64'd3, 64'd3);
    @(negedge I_sys_clk);
    I_start = 1'b0;
    chk("bad_opsel", {62'd0, O_out_valid, O_busy}, 64'd0);

    // Flush and start in the same idle cycle: nothing latched
    drive(M_DIV, 1'b0, 1'b0, 64'd5, 64'd0);
    I_flush = 1'b1;
    @(negedge I_sys_clk);
    I_start = 1'b0;
    I_flush = 1'b0;
    chk("flush_start", {62'd0, O_out_valid, O_busy}, 64'd0);

    // Flush mid-CALC at t+20, back to IDLE at t+21, new op at t+22
    drive(M_DIV, 1'b0, 1'b0, 64'd100, 64'd7);
    seen = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge I_sys_clk);
      I_start = 1'b0;
      I_flush = (k == 20);
      if (O_out_valid) seen = 1'b1;
    end
    chk("flush_idle", {62'd0, O_out_valid, O_busy}, 64'd0);
    chk("flush_novalid", {63'd0, seen}, 64'd0);
    run_op("post_flush", M_DIV, 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 65);

    // Reset mid-CALC clears everything next cycle
    @(negedge I_sys_clk);
    drive(M_MUL, 1'b0, 1'b0, 64'd9, 64'd9);
    repeat (10) begin
      @(negedge I_sys_clk);
      I_start = 1'b0;
    end
    I_rst = 1'b1;
    @(negedge I_sys_clk);
    chk("rst_mid", {O_result[61:0], O_out_valid, O_busy}, 64'd0);
    I_rst = 1'b0;
    run_op("post_rst", M_MUL, 1'b0, 1'b0, 64'd9, 64'd9, 64'd81, mul_lat(65));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
